// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box table, GF(2^8) xtime, MixColumns column operation,
// word substitution, FSM state encoding and the round count for a key length.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_state_e;

   // Entry 0 sits in the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic int nr_for(input int key_bits);
      return (key_bits == 256) ? 14 : 10;
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped when last is high) and AddRoundKey.
module aes_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] state_nxt
);

   logic [127:0] sr;
   logic [127:0] mc;

   // Byte i of the block is row i%4, column i/4; row r rotates left by r.
   always_comb begin
      sr = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127 - 8*(4*c + r) -: 8] = sbox(state[127 - 8*(4*((c + r) % 4) + r) -: 8]);
         end
      end
   end

   always_comb begin
      mc = '0;
      for (int c = 0; c < 4; c++) begin
         mc[127 - 32*c -: 32] = mix_column(sr[127 - 32*c -: 32]);
      end
   end

   assign state_nxt = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor, one round per clk, on-the-fly key schedule.
// Define AES_ITER_ZEROIZE_EN to wipe state/keys on output handshake and mask out_data.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | applying round round_q this cycle
// DONE  | ciphertext held on out_data until out_ready
module aes_iter_core
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_data,
   input  logic [KEY_BITS-1:0] in_key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_data,
   output logic                busy
);

   localparam int         NR   = nr_for(KEY_BITS);
   localparam logic [3:0] NR_L = 4'(NR);

   if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_iter_core: KEY_BITS must be 128 or 256");
   end

   aes_state_e   fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] state_q, state_d;
   logic [127:0] ka_q, ka_d;
   logic [127:0] kb_q, kb_d;
   logic [127:0] key_exp;
   logic [127:0] rk;
   logic [127:0] round_out;
   logic         rot_step;

   // AES-256 alternates RotWord+SubWord+rcon (odd steps) with SubWord only.
   assign rot_step = (KEY_BITS == 128) || round_q[0];

   always_comb begin
      logic [31:0] w;
      logic [31:0] t;
      w = (KEY_BITS == 256) ? kb_q[31:0] : ka_q[31:0];
      if (rot_step) begin
         w = {w[23:0], w[31:24]};
      end
      t = sub_word(w) ^ (rot_step ? {rcon_q, 24'h0} : 32'h0);
      key_exp[127:96] = ka_q[127:96] ^ t;
      key_exp[95:64]  = ka_q[95:64]  ^ ka_q[127:96] ^ t;
      key_exp[63:32]  = ka_q[63:32]  ^ ka_q[95:64]  ^ ka_q[127:96] ^ t;
      key_exp[31:0]   = ka_q[31:0]   ^ ka_q[63:32]  ^ ka_q[95:64]  ^ ka_q[127:96] ^ t;
   end

   // For 128-bit keys the round key is produced combinationally alongside the round.
   assign rk = (KEY_BITS == 256) ? kb_q : key_exp;

   aes_round u_round (
      .state     (state_q),
      .rk        (rk),
      .last      (round_q == NR_L),
      .state_nxt (round_out)
   );

   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      state_d = state_q;
      ka_d    = ka_q;
      kb_d    = kb_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_d = in_data ^ in_key[KEY_BITS-1 -: 128];
               ka_d    = in_key[KEY_BITS-1 -: 128];
               kb_d    = in_key[127:0];
               round_d = 4'd1;
               rcon_d  = 8'h01;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = round_out;
            round_d = round_q + 4'd1;
            if (rot_step) begin
               rcon_d = xtime(rcon_q);
            end
            if (KEY_BITS == 256) begin
               ka_d = kb_q;
               kb_d = key_exp;
            end else begin
               ka_d = key_exp;
            end
            if (round_q == NR_L) begin
               fsm_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d = IDLE;
`ifdef AES_ITER_ZEROIZE_EN
               state_d = '0;
               ka_d    = '0;
               kb_d    = '0;
               rcon_d  = '0;
`endif
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         round_q <= '0;
         rcon_q  <= 8'h01;
         state_q <= '0;
         ka_q    <= '0;
         kb_q    <= '0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
         state_q <= state_d;
         ka_q    <= ka_d;
         kb_q    <= kb_d;
      end
   end

   assign in_ready  = (fsm_q == IDLE);
   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q != IDLE);

`ifdef AES_ITER_ZEROIZE_EN
   assign out_data = out_valid ? state_q : 128'h0;
`else
   assign out_data = state_q;
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboard bench for aes_iter_core: one 128-bit and one 256-bit instance,
// FIPS-197 vectors; post-handshake expectation follows AES_ITER_ZEROIZE_EN.
module tb_aes_iter_core;

   localparam logic [255:0] KEY_A128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
   localparam logic [255:0] KEY_A256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_A     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_A128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_A256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEY_B128 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
   localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B128  = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_ITER_ZEROIZE_EN
   localparam logic [127:0] POST_HS  = 128'h0;
`else
   localparam logic [127:0] POST_HS  = CT_B128;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   iv, ir, ov, orr, bsy;
   logic [127:0] din  [2];
   logic [127:0] dout [2];
   logic [127:0] k128;
   logic [255:0] k256;
   logic [1:0]   prev_ov;
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;
   logic [127:0] expq [2][$];
   int           accq [2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_iter_core #(.KEY_BITS(128)) u128 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0]),
      .in_key(k128), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(dout[0]), .busy(bsy[0])
   );

   aes_iter_core #(.KEY_BITS(256)) u256 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1]),
      .in_key(k256), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(dout[1]), .busy(bsy[1])
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: latency from handshake cycle to out_valid rise, and data on output handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov <= 2'b00;
      end else begin
         for (int g = 0; g < 2; g++) begin
            if (iv[g] && ir[g]) accq[g].push_back(cyc);
            if (ov[g] && !prev_ov[g]) begin
               if (accq[g].size() == 0) chki("latency_no_accept", 0, 1);
               else chki(g == 0 ? "latency128" : "latency256", cyc - accq[g].pop_front(), g == 0 ? 11 : 15);
            end
            if (ov[g] && orr[g]) begin
               if (expq[g].size() == 0) chki("unexpected_output", 0, 1);
               else chk(g == 0 ? "out_data128" : "out_data256", dout[g], expq[g].pop_front());
            end
         end
         prev_ov <= ov;
      end
   end

   task automatic send(input int g, input logic [127:0] pt, input logic [255:0] key, input logic [127:0] ct);
      int n = 0;
      din[g] = pt;
      if (g == 0) k128 = key[127:0];
      else k256 = key;
      iv[g] = 1'b1;
      expq[g].push_back(ct);
      while (!ir[g] && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chki("accept_wait", int'(ir[g]), 1);
      @(posedge clk); #1;
      iv[g] = 1'b0;
      din[g] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      if (g == 0) k128 = ~key[127:0];
      else k256 = ~key;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((expq[0].size() != 0 || expq[1].size() != 0) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chki("drain_empty", expq[0].size() + expq[1].size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      iv = 2'b00;
      orr = 2'b11;
      din[0] = '0;
      din[1] = '0;
      k128 = '0;
      k256 = '0;
      #23;
      chki("rst_in_ready", int'(ir[0]), 1);
      chki("rst_out_valid", int'(ov[0]), 0);
      chki("rst_busy", int'(bsy[0]), 0);
      chk("rst_out_data", dout[0], 128'h0);
      chk("rst_out_data256", dout[1], 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Both key lengths, FIPS-197 appendix C vectors, run concurrently.
      send(0, PT_A, KEY_A128, CT_A128);
      send(1, PT_A, KEY_A256, CT_A256);
      drain(60);

      // Output stall with ignored in_valid pulses.
      orr[0] = 1'b0;
      send(0, PT_B, KEY_B128, CT_B128);
      n = 0;
      while (!ov[0] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chki("stall_valid", int'(ov[0]), 1);
      for (int i = 0; i < 20; i++) begin
         chk("stall_data", dout[0], CT_B128);
         chki("stall_in_ready", int'(ir[0]), 0);
         if (i == 4) begin
            iv[0] = 1'b1;
            din[0] = PT_A;
            k128 = KEY_A128[127:0];
         end
         if (i == 8) iv[0] = 1'b0;
         @(posedge clk); #1;
      end
      orr[0] = 1'b1;
      @(posedge clk); #1;
      chki("post_hs_valid", int'(ov[0]), 0);
      chki("post_hs_in_ready", int'(ir[0]), 1);
      chk("post_hs_data", dout[0], POST_HS);
      drain(5);

      // Back-to-back with in_valid and out_ready held high.
      din[0] = PT_A;
      k128 = KEY_A128[127:0];
      iv[0] = 1'b1;
      expq[0].push_back(CT_A128);
      @(posedge clk); #1;
      chki("b2b_busy", int'(bsy[0]), 1);
      din[0] = PT_B;
      k128 = KEY_B128[127:0];
      expq[0].push_back(CT_B128);
      n = 0;
      while (!ir[0] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chki("b2b_period", n + 1, 12);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      drain(40);

      // Asynchronous reset in the middle of round 5.
      send(0, PT_A, KEY_A128, CT_A128);
      repeat (4) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      chki("midrst_busy", int'(bsy[0]), 0);
      chki("midrst_in_ready", int'(ir[0]), 1);
      chki("midrst_out_valid", int'(ov[0]), 0);
      chk("midrst_out_data", dout[0], 128'h0);
      expq[0].delete();
      accq[0].delete();
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      send(0, PT_B, KEY_B128, CT_B128);
      drain(40);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
